axi_b_snoop_fifo: RTL

Snoops the AXI4 write-response (B) channel between an AXI master and slave. Pushes a stream-formatted copy of every completed B handshake into an internal FIFO, then drains it on a single-beat stream port toward the EthHelper stream arbiter. The FIFO decouples the B path from downstream stream back-pressure, so the B path is not stalled on every transfer. A compile-time mode selects whether a full FIFO stalls the B channel or drops the snooped copy.

---
 rtl/eth_helper_pkg.sv | 19 +
 rtl/snoop_fifo.sv | 54 +++++
 rtl/axi_b_snoop_fifo.sv | 102 ++++++++++
 3 files changed

// File: rtl/eth_helper_pkg.sv
// rtl/eth_helper_pkg.sv - shared stream tags and AXI B snoop entry type for the EthHelper stream arbiter
package eth_helper_pkg;

    localparam int STREAM_TYPE_WIDTH = 3;

    localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_AW = 3'b000;
    localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_W  = 3'b001;
    localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_AR = 3'b010;
    localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_R  = 3'b011;
    localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_B  = 3'b100;

    localparam int B_ID_WIDTH = 32;

    typedef struct packed {
        logic [B_ID_WIDTH-1:0] bid;
        logic [1:0]            bresp;
    } b_snoop_entry_t;

endpackage

// File: rtl/snoop_fifo.sv
// rtl/snoop_fifo.sv - register-array FIFO with wrap-bit pointers used to buffer snooped B beats
module snoop_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra MSB distinguishes full from empty when the index bits coincide.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/axi_b_snoop_fifo.sv
// rtl/axi_b_snoop_fifo.sv - AXI4 B-channel snooper feeding a single-beat stream; AXI_B_SNOOP_DROP_CNT_EN adds drop_count
module axi_b_snoop_fifo
    import eth_helper_pkg::*;
#(
    parameter int DATA_WIDTH        = 128,
    parameter int ID_WIDTH          = 32,
    parameter int USER_WIDTH        = 64,
    parameter int STREAM_TYPE_WIDTH = eth_helper_pkg::STREAM_TYPE_WIDTH,
    parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE = STREAM_TYPE_B,
    parameter int DEPTH             = 4,
    parameter int BACKPRESSURE      = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ready,
    output logic                       valid,
    output logic                       in_progress,
    output logic                       last,
    output logic [DATA_WIDTH-1:0]      data,
    output logic [$clog2(DEPTH):0]     count,
    output logic [ID_WIDTH-1:0]        AXIS_bid,
    output logic [1:0]                 AXIS_bresp,
    output logic [USER_WIDTH-1:0]      AXIS_buser,
    output logic                       AXIS_bvalid,
    input  logic                       AXIS_bready,
    input  logic [ID_WIDTH-1:0]        AXIM_bid,
    input  logic [1:0]                 AXIM_bresp,
    input  logic [USER_WIDTH-1:0]      AXIM_buser,
    input  logic                       AXIM_bvalid,
    output logic                       AXIM_bready
`ifdef AXI_B_SNOOP_DROP_CNT_EN
    ,
    output logic [15:0]                drop_count
`endif
);

    localparam int  EW     = ID_WIDTH + 2;
    localparam logic BP_OFF = (BACKPRESSURE == 0);

    logic          full;
    logic          empty;
    logic          gate;
    logic          hs;
    logic          fifo_push;
    logic          fifo_pop;
    logic [EW-1:0] head;

    // During reset the B channel must never be masked, regardless of FIFO state.
    assign gate        = reset | ~full | BP_OFF;
    assign AXIS_bid    = AXIM_bid;
    assign AXIS_bresp  = AXIM_bresp;
    assign AXIS_buser  = AXIM_buser;
    assign AXIS_bvalid = AXIM_bvalid & gate;
    assign AXIM_bready = AXIS_bready & gate;
    assign hs          = AXIM_bvalid & AXIM_bready;
    assign fifo_push   = hs & ~reset & ~full;
    assign fifo_pop    = valid & ready;

    assign valid       = ~empty;
    assign in_progress = valid;
    assign last        = valid;

    snoop_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({AXIM_bid, AXIM_bresp}),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Payload is masked while empty so stale storage never leaks onto the stream.
    always_comb begin
        data = '0;
        data[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH] = STREAM_TYPE;
        if (valid) begin
            data[DATA_WIDTH-STREAM_TYPE_WIDTH-1 -: ID_WIDTH] = head[EW-1:2];
            data[1:0] = head[1:0];
        end
    end

`ifdef AXI_B_SNOOP_DROP_CNT_EN
    logic drop;

    assign drop = hs & ~reset & full;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule
